// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction fields back into a 32-bit RV32 word.
// Used in the debug/difftest path so the monitor can inject instructions
// (ebreak stubs, CSR pokes) into the IFU instruction stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   field bundle handshake (in_ready is registered)
//   fmt                   000 I, 001 U, 010 S, 011 B, 100 J, 101 R, 11x illegal
//   opcode, funct3, funct7, rd, rs1, rs2, imm   decoded fields
//   out_valid / out_ready encoded word handshake
//   inst, err             encoded word; err flags an unrepresentable immediate
//                         or an illegal fmt (qualified by out_valid)
//   cnt_ok, cnt_err       saturating counts of emitted words by err value
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  logic [31:0] enc_inst;
  logic        enc_err;
  logic        i_ok, u_ok, b_ok, j_ok;

  // An immediate fits when every bit above the field's sign bit copies it.
  assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign u_ok = ~(|imm[11:0]);
  assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    case (fmt)
      3'b000: begin
        enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err  = ~i_ok;
      end
      3'b001: begin
        enc_inst = {imm[31:12], rd, opcode};
        enc_err  = ~u_ok;
      end
      3'b010: begin
        enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err  = ~i_ok;
      end
      3'b011: begin
        enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err  = ~b_ok;
      end
      3'b100: begin
        enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_err  = ~j_ok;
      end
      3'b101: begin
        enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err  = 1'b0;
      end
      default: begin
        enc_inst = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register plus one skid entry. The skid only fills when a bundle is
  // accepted while the output register holds a word that is not draining.
  logic        skid_valid, skid_next;
  logic [31:0] skid_inst;
  logic        skid_err;
  logic        accept, emit, out_free;

  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;
  assign out_free = !out_valid || emit;

  always_comb begin
    skid_next = skid_valid;
    if (skid_valid) begin
      skid_next = !out_free;
    end else if (accept && !out_free) begin
      skid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      inst       <= 32'h0;
      err        <= 1'b0;
      skid_valid <= 1'b0;
      skid_inst  <= 32'h0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          inst      <= skid_inst;
          err       <= skid_err;
          out_valid <= 1'b1;
        end else if (accept) begin
          inst      <= enc_inst;
          err       <= enc_err;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_inst <= enc_inst;
        skid_err  <= enc_err;
      end
      skid_valid <= skid_next;
      // Registered ready: drops as soon as the skid holds a word so no third
      // bundle can ever be accepted.
      in_ready   <= !skid_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (emit) begin
      if (err) begin
        if (cnt_err != {CNT_W{1'b1}}) cnt_err <= cnt_err + CNT_W'(1);
      end else begin
        if (cnt_ok != {CNT_W{1'b1}}) cnt_ok <= cnt_ok + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed encodings, range errors, backpressure,
// asynchronous reset mid-transfer, counter saturation and a randomized stream
// scored against a behavioural model.
module tb_inst_encoder;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      inst;
  logic             err;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_err;

  inst_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];
  int unsigned m_ok = 0;
  int unsigned m_err = 0;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Reference encoding from field positions and the numeric immediate ranges.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    int unsigned w, uop, uf3, uf7, ud, us1, us2, ui;
    int sv;
    bit e;
    uop = op; uf3 = f3; uf7 = f7; ud = d; us1 = s1; us2 = s2; ui = im;
    sv = $signed(im);
    w = 0;
    e = 0;
    case (f)
      3'd0: begin
        w = ((ui & 32'hFFF) << 20) | (us1 << 15) | (uf3 << 12) | (ud << 7) | uop;
        e = (sv < -2048) || (sv > 2047);
      end
      3'd1: begin
        w = (ui & 32'hFFFFF000) | (ud << 7) | uop;
        e = (ui % 4096) != 0;
      end
      3'd2: begin
        w = (((ui >> 5) & 32'h7F) << 25) | (us2 << 20) | (us1 << 15) | (uf3 << 12)
          | ((ui & 32'h1F) << 7) | uop;
        e = (sv < -2048) || (sv > 2047);
      end
      3'd3: begin
        w = (((ui >> 12) & 1) << 31) | (((ui >> 5) & 32'h3F) << 25) | (us2 << 20)
          | (us1 << 15) | (uf3 << 12) | (((ui >> 1) & 32'hF) << 8)
          | (((ui >> 11) & 1) << 7) | uop;
        e = (sv < -4096) || (sv > 4095) || (ui % 2 != 0);
      end
      3'd4: begin
        w = (((ui >> 20) & 1) << 31) | (((ui >> 1) & 32'h3FF) << 21)
          | (((ui >> 11) & 1) << 20) | (((ui >> 12) & 32'hFF) << 12) | (ud << 7) | uop;
        e = (sv < -(1 << 20)) || (sv >= (1 << 20)) || (ui % 2 != 0);
      end
      3'd5: begin
        w = (uf7 << 25) | (us2 << 20) | (us1 << 15) | (uf3 << 12) | (ud << 7) | uop;
        e = 0;
      end
      default: begin
        w = 0;
        e = 1;
      end
    endcase
    return {e, w};
  endfunction

  // Scoreboard monitor: counters, in-flight bound, emitted words in order.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [32:0] exp_w;
      checks++;
      if (cnt_ok !== CNT_W'(m_ok) || cnt_err !== CNT_W'(m_err)) begin
        errors++;
        $display("FAIL counters: got ok=%0d err=%0d expected ok=%0d err=%0d",
                 cnt_ok, cnt_err, m_ok, m_err);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got inst=%h with no bundle outstanding", inst);
        end else begin
          exp_w = sb.pop_front();
          if (inst !== exp_w[31:0] || err !== exp_w[32]) begin
            errors++;
            $display("FAIL scoreboard: got inst=%h err=%b expected inst=%h err=%b",
                     inst, err, exp_w[31:0], exp_w[32]);
          end
          if (exp_w[32]) begin
            if (m_err < CNT_MAX) m_err++;
          end else begin
            if (m_ok < CNT_MAX) m_ok++;
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm));
      checks++;
      if (sb.size() > 2) begin
        errors++;
        $display("FAIL in_flight: got %0d outstanding expected at most 2", sb.size());
      end
    end
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] im);
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic rand_bundle();
    logic [31:0] im;
    case ($urandom_range(0, 3))
      0: im = $urandom;
      1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: im = {$urandom_range(0, 32'hFFFFF), 12'h0} & 32'hFFFFF000;
      default: im = 32'($urandom_range(0, 1 << 22)) - 32'd2097152;
    endcase
    set_fields(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), im);
  endtask

  // Holds in_valid with the current fields until accepted (bounded wait).
  task automatic drive_accept();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_ok = 0;
    m_err = 0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_fields(3'd0, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0);
    in_valid = 1'b0;
    #7;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || inst !== 32'h0 || err !== 1'b0 ||
        cnt_ok !== '0 || cnt_err !== '0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b ir=%b inst=%h err=%b ok=%0d cerr=%0d expected 0 1 0 0 0 0",
               out_valid, in_ready, inst, err, cnt_ok, cnt_err);
    end
    #15;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] exp_i[6];
    logic        exp_e[6];
    logic [32:0] flds[6];
    out_ready = 1'b1;
    exp_i = '{32'hFFF10093, 32'hFE208EE3, 32'h0010006F, 32'h80000000, 32'h0, 32'h0};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: set_fields(3'b000, 7'h13, 3'h0, 7'h0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
        1: set_fields(3'b011, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        2: set_fields(3'b100, 7'h6F, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h00000800);
        3: set_fields(3'b000, 7'h00, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h00000800);
        4: set_fields(3'b011, 7'h63, 3'h0, 7'h0, 5'd0, 5'd1, 5'd2, 32'h00000003);
        default: set_fields(3'b110, 7'h13, 3'h1, 7'h1, 5'd3, 5'd4, 5'd5, 32'h12345678);
      endcase
      drive_accept();
      @(negedge clk);
      checks++;
      if (k == 3 || k == 4) begin
        if (err !== 1'b1 || (k == 3 && inst[31:20] !== 12'h800)) begin
          errors++;
          $display("FAIL directed_%0d: got inst=%h err=%b expected err=1 inst[31:20]=800 for I",
                   k, inst, err);
        end
      end else if (out_valid !== 1'b1 || inst !== exp_i[k] || err !== exp_e[k]) begin
        errors++;
        $display("FAIL directed_%0d: got ov=%b inst=%h err=%b expected ov=1 inst=%h err=%b",
                 k, out_valid, inst, err, exp_i[k], exp_e[k]);
      end
      @(negedge clk);
      checks++;
      if (cnt_ok !== CNT_W'(k < 3 ? k + 1 : 3) || cnt_err !== CNT_W'(k < 3 ? 0 : k - 2)) begin
        errors++;
        $display("FAIL directed_cnt_%0d: got ok=%0d err=%0d expected ok=%0d err=%0d",
                 k, cnt_ok, cnt_err, (k < 3 ? k + 1 : 3), (k < 3 ? 0 : k - 2));
      end
      @(posedge clk); #1;
    end
    flds[0] = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_fields(3'b101, 7'h33, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), $urandom);
      drive_accept();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_ok !== CNT_W'(3) || cnt_err !== '0) begin
      errors++;
      $display("FAIL saturation: got ok=%0d err=%0d expected ok=3 err=0", cnt_ok, cnt_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    rand_bundle();
    drive_accept();
    rand_bundle();
    drive_accept();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: got ir=%b ov=%b expected ir=0 ov=1", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    m_ok = 0;
    m_err = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_ok !== '0 || cnt_err !== '0 ||
        inst !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b ir=%b ok=%0d err=%0d inst=%h expected 0 1 0 0 0",
               out_valid, in_ready, cnt_ok, cnt_err, inst);
    end
    #6;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset: got ov=%b expected 0 (cycle %0d)", out_valid, k);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    rand_bundle();
    drive_accept();
    rand_bundle();
    drive_accept();
    rand_bundle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall_%0d: got ir=%b ov=%b expected ir=0 ov=1", k, in_ready, out_valid);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_emit_0: got ov=%b expected 1", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_emit_1: got ov=%b ir=%b expected ov=1 ir=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_emit_2: got ov=%b expected 1", out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got ov=%b outstanding=%0d expected ov=0 outstanding=0",
               out_valid, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic acc = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        rand_bundle();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got outstanding=%0d ov=%b expected 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
